// File: rtl/load_scoreboard.sv
// Load scoreboard: tracks in-flight load destinations from ID issue to WB.
// Produces ID stall, EX bubble and issue so forwarding never sees load data early.
module load_scoreboard #(
  parameter int MAX_LOADS = 2,
  parameter int CNT_W     = $clog2(MAX_LOADS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic             id_rs1_used,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             ex_flush,
  input  logic             mem_busy,
  input  logic             wb_valid,
  input  logic             wb_RegWrite,
  input  logic             wb_MemRead,
  input  logic [4:0]       wb_rd_addr,
  output logic             stall_id,
  output logic             ex_bubble,
  output logic             issue,
  output logic [31:0]      pending_mask,
  output logic [CNT_W-1:0] outstanding
);

  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_is_load_q, ex_is_load_d;
  logic [4:0]       ex_rd_q, ex_rd_d;

  logic             retire;
  logic             set;
  logic             kill;
  logic [31:0]      eff_pending;
  logic [CNT_W-1:0] cnt_eff;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             cap;
  logic             hazard;
  logic             stall_c;
  logic             issue_c;
  logic [CNT_W:0]   cnt_up;
  logic [CNT_W:0]   cnt_dn;

  always_comb begin
    retire = wb_valid & wb_RegWrite & wb_MemRead
           & (wb_rd_addr != 5'd0);
    // write-first regfile: a retiring load is already readable
    eff_pending = pending_q;
    if (retire) eff_pending[wb_rd_addr] = 1'b0;
  end

  always_comb begin
    raw1 = id_rs1_used & (id_rs1_addr != 5'd0)
         & eff_pending[id_rs1_addr];
    raw2 = id_rs2_used & (id_rs2_addr != 5'd0)
         & eff_pending[id_rs2_addr];
    waw  = id_RegWrite & (id_rd_addr != 5'd0)
         & eff_pending[id_rd_addr];
    cnt_eff = cnt_q - CNT_W'(retire);
    cap  = id_MemRead & id_RegWrite
         & (id_rd_addr != 5'd0)
         & (cnt_eff == CNT_W'(MAX_LOADS));
    hazard = raw1 | raw2 | waw | cap;
  end

  always_comb begin
    stall_c = mem_busy | (id_valid & hazard & ~ex_flush);
    issue_c = id_valid & ~stall_c & ~ex_flush;
    set     = issue_c & id_RegWrite & id_MemRead
            & (id_rd_addr != 5'd0);
    kill    = ex_flush & ~mem_busy & ex_is_load_q;
  end

  always_comb begin
    stall_id     = rst | stall_c;
    issue        = ~rst & issue_c;
    ex_bubble    = ~rst & ~mem_busy & ~issue_c;
    pending_mask = rst ? 32'd0 : pending_q;
    outstanding  = rst ? '0 : cnt_q;
  end

  always_comb begin
    pending_d = pending_q;
    if (retire) pending_d[wb_rd_addr] = 1'b0;
    if (kill)   pending_d[ex_rd_q]    = 1'b0;
    if (set)    pending_d[id_rd_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // set/kill are already zero during a freeze; retire still drains
  always_comb begin
    cnt_up = {1'b0, cnt_q} + (CNT_W+1)'(set);
    cnt_dn = (CNT_W+1)'(retire) + (CNT_W+1)'(kill);
    if (cnt_up < cnt_dn) cnt_d = '0;
    else                 cnt_d = CNT_W'(cnt_up - cnt_dn);
  end

  always_comb begin
    ex_is_load_d = ex_is_load_q;
    ex_rd_d      = ex_rd_q;
    if (!mem_busy) begin
      ex_is_load_d = set;
      ex_rd_d      = issue_c ? id_rd_addr : 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= 32'd0;
      cnt_q        <= '0;
      ex_is_load_q <= 1'b0;
      ex_rd_q      <= 5'd0;
    end else begin
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      ex_is_load_q <= ex_is_load_d;
      ex_rd_q      <= ex_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!((retire | kill) && (cnt_q == '0)));
      assert (!(retire && kill && (ex_rd_q == wb_rd_addr)));
    end
  end

endmodule

// File: tb/tb_load_scoreboard.sv
// Bench for load_scoreboard: directed hazard scenarios then random traffic,
// checked against a queue-based model of loads in flight.
module tb_load_scoreboard;

  localparam int MAXL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic        id_rs1_used;
  logic [4:0]  id_rs2_addr;
  logic        id_rs2_used;
  logic [4:0]  id_rd_addr;
  logic        id_RegWrite;
  logic        id_MemRead;
  logic        ex_flush;
  logic        mem_busy;
  logic        wb_valid;
  logic        wb_RegWrite;
  logic        wb_MemRead;
  logic [4:0]  wb_rd_addr;
  logic        stall_id;
  logic        ex_bubble;
  logic        issue;
  logic [31:0] pending_mask;
  logic [1:0]  outstanding;

  always #5 clk = ~clk;

  load_scoreboard #(.MAX_LOADS(MAXL)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .ex_flush(ex_flush), .mem_busy(mem_busy),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
    .wb_MemRead(wb_MemRead), .wb_rd_addr(wb_rd_addr),
    .stall_id(stall_id), .ex_bubble(ex_bubble),
    .issue(issue), .pending_mask(pending_mask),
    .outstanding(outstanding)
  );

  int checks = 0;
  int passes = 0;

  // loads past EX, plus the load (if any) currently in EX
  int q[$];
  bit m_ex_load = 1'b0;
  int m_ex_rd   = 0;
  bit r_ret, r_set, r_kill;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = 32'd0;
    foreach (q[i]) m |= 32'd1 << q[i];
    if (m_ex_load) m |= 32'd1 << m_ex_rd;
    return m;
  endfunction

  task automatic eval();
    logic [31:0] mask, eff;
    int  cnt;
    bit  haz, e_stall, e_issue, e_bub;
    #1;
    mask = model_mask();
    cnt  = q.size() + int'(m_ex_load);
    if (rst) begin
      chk("rst_stall", stall_id, 1);
      chk("rst_issue", issue, 0);
      chk("rst_bubble", ex_bubble, 0);
      chk("rst_mask", pending_mask, 0);
      chk("rst_out", outstanding, 0);
      r_ret = 0; r_set = 0; r_kill = 0;
    end else begin
      r_ret = wb_valid && wb_RegWrite && wb_MemRead
              && wb_rd_addr != 0;
      eff = mask;
      if (r_ret) eff[wb_rd_addr] = 1'b0;
      haz = (id_rs1_used && id_rs1_addr != 0
             && eff[id_rs1_addr])
         || (id_rs2_used && id_rs2_addr != 0
             && eff[id_rs2_addr])
         || (id_RegWrite && id_rd_addr != 0
             && eff[id_rd_addr])
         || (id_MemRead && id_RegWrite && id_rd_addr != 0
             && cnt - int'(r_ret) == MAXL);
      e_stall = mem_busy || (id_valid && haz && !ex_flush);
      e_issue = id_valid && !e_stall && !ex_flush;
      e_bub   = !mem_busy && !e_issue;
      r_set   = e_issue && id_RegWrite && id_MemRead
                && id_rd_addr != 0;
      r_kill  = ex_flush && !mem_busy && m_ex_load;
      chk("stall_id", stall_id, e_stall);
      chk("issue", issue, e_issue);
      chk("ex_bubble", ex_bubble, e_bub);
      chk("pending_mask", pending_mask, mask);
      chk("outstanding", outstanding, cnt);
    end
  endtask

  task automatic tick();
    if (rst) begin
      q.delete();
      m_ex_load = 0;
      m_ex_rd   = 0;
    end else begin
      if (r_ret) begin
        for (int i = 0; i < q.size(); i++)
          if (q[i] == int'(wb_rd_addr)) begin
            q.delete(i);
            break;
          end
      end
      if (!mem_busy) begin
        if (m_ex_load && !r_kill) q.push_back(m_ex_rd);
        m_ex_load = r_set;
        m_ex_rd   = int'(id_rd_addr);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    eval();
    tick();
  endtask

  task automatic idle();
    rst = 0; id_valid = 0;
    id_rs1_addr = 0; id_rs1_used = 0;
    id_rs2_addr = 0; id_rs2_used = 0;
    id_rd_addr = 0; id_RegWrite = 0; id_MemRead = 0;
    ex_flush = 0; mem_busy = 0;
    wb_valid = 0; wb_RegWrite = 0;
    wb_MemRead = 0; wb_rd_addr = 0;
  endtask

  task automatic id_in(logic [4:0] rs1, bit u1,
                       logic [4:0] rs2, bit u2,
                       logic [4:0] rd, bit rw, bit mr);
    id_valid = 1;
    id_rs1_addr = rs1; id_rs1_used = u1;
    id_rs2_addr = rs2; id_rs2_used = u2;
    id_rd_addr = rd; id_RegWrite = rw; id_MemRead = mr;
  endtask

  task automatic wb_ret(logic [4:0] rd);
    wb_valid = 1; wb_RegWrite = 1;
    wb_MemRead = 1; wb_rd_addr = rd;
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    step();
    step();

    // load-use
    idle(); id_in(2, 1, 0, 0, 5, 1, 1); step();
    idle(); id_in(5, 1, 1, 1, 6, 1, 0);
    eval();
    chk("lu_mask", pending_mask, 32'h20);
    chk("lu_stall", stall_id, 1);
    chk("lu_bubble", ex_bubble, 1);
    tick();
    eval(); chk("lu_stall2", stall_id, 1); tick();
    wb_ret(5);
    eval();
    chk("lu_ret_stall", stall_id, 0);
    chk("lu_ret_issue", issue, 1);
    tick();
    idle(); eval(); chk("lu_clear", pending_mask, 0); tick();

    // same-cycle bypass
    idle(); id_in(0, 0, 0, 0, 7, 1, 1); step();
    idle(); step(); step();
    id_in(1, 1, 7, 1, 8, 1, 0); wb_ret(7);
    eval();
    chk("byp_pre", pending_mask, 32'h80);
    chk("byp_stall", stall_id, 0);
    tick();
    idle(); eval(); chk("byp_bit7", pending_mask[7], 0); tick();

    // capacity
    idle(); id_in(0, 0, 0, 0, 1, 1, 1); step();
    idle(); id_in(0, 0, 0, 0, 2, 1, 1); step();
    idle(); id_in(0, 0, 0, 0, 3, 1, 1);
    eval(); chk("cap_stall", stall_id, 1); tick();
    wb_ret(1);
    eval(); chk("cap_issue", issue, 1); tick();
    idle();
    eval();
    chk("cap_out", outstanding, 2);
    chk("cap_mask", pending_mask, 32'hC);
    tick();
    wb_ret(2); step();
    idle(); wb_ret(3); step();
    idle(); eval(); chk("cap_drain", outstanding, 0); tick();

    // flush of a load in EX
    idle(); id_in(0, 0, 0, 0, 9, 1, 1); step();
    idle(); id_in(1, 1, 2, 1, 11, 1, 0); ex_flush = 1;
    eval();
    chk("fl_out_pre", outstanding, 1);
    chk("fl_issue", issue, 0);
    chk("fl_bubble", ex_bubble, 1);
    tick();
    idle();
    eval();
    chk("fl_mask", pending_mask, 0);
    chk("fl_out", outstanding, 0);
    tick();

    // memory freeze with retire in the middle
    idle(); id_in(0, 0, 0, 0, 4, 1, 1); step();
    idle(); step();
    id_in(0, 0, 0, 0, 10, 1, 1); mem_busy = 1;
    eval();
    chk("frz_stall1", stall_id, 1);
    chk("frz_bub1", ex_bubble, 0);
    tick();
    wb_ret(4);
    eval();
    chk("frz_stall2", stall_id, 1);
    chk("frz_bub2", ex_bubble, 0);
    tick();
    wb_valid = 0; wb_MemRead = 0;
    eval();
    chk("frz_mask", pending_mask, 0);
    chk("frz_issue3", issue, 0);
    chk("frz_bub3", ex_bubble, 0);
    tick();
    mem_busy = 0;
    eval(); chk("frz_release", issue, 1); tick();
    idle(); step();
    wb_ret(10); step();

    // reset mid-operation
    idle(); id_in(0, 0, 0, 0, 5, 1, 1); step();
    idle(); id_in(0, 0, 0, 0, 8, 1, 1); step();
    idle();
    eval();
    chk("rs_mask_pre", pending_mask, 32'h120);
    chk("rs_out_pre", outstanding, 2);
    tick();
    rst = 1; id_in(0, 0, 0, 0, 12, 1, 1);
    eval(); chk("rs_stall", stall_id, 1); tick();
    idle();
    eval();
    chk("rs_mask", pending_mask, 0);
    chk("rs_out", outstanding, 0);
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      id_valid    = ($urandom_range(0, 99) < 80);
      id_rs1_addr = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_addr = 5'($urandom_range(0, 7));
      id_rs2_used = 1'($urandom_range(0, 1));
      id_rd_addr  = 5'($urandom_range(0, 7));
      id_RegWrite = ($urandom_range(0, 99) < 80);
      id_MemRead  = ($urandom_range(0, 99) < 40);
      ex_flush    = ($urandom_range(0, 99) < 10);
      mem_busy    = ($urandom_range(0, 99) < 15);
      if (q.size() > 0 && $urandom_range(0, 99) < 40) begin
        wb_ret(5'(q[$urandom_range(0, q.size() - 1)]));
      end else begin
        wb_valid    = 1'($urandom_range(0, 1));
        wb_RegWrite = 1'($urandom_range(0, 1));
        wb_MemRead  = 0;
        wb_rd_addr  = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 9) == 0) begin
          wb_MemRead = 1;
          wb_rd_addr = 0;
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/load_scoreboard.md
Name: load_scoreboard

Overview:
- Producer-side companion to the EX-stage forwarding logic.
- Tracks destination registers of in-flight loads, whose data cannot be forwarded from MEM, from issue in ID until writeback.
- Drives ID stall and EX bubble so that forwarding only ever sees operands that are legally available.
- Sits beside the ID/EX pipeline register; consumes ID decode, EX flush, MEM busy and WB retire information.

Parameters:
- MAX_LOADS, 2, maximum loads simultaneously in flight (1..15).
- CNT_W, $clog2(MAX_LOADS+1), width of the outstanding-load counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- id_valid  input  1  valid instruction in ID.
- id_rs1_addr  input  5  ID source register 1.
- id_rs1_used  input  1  instruction reads rs1.
- id_rs2_addr  input  5  ID source register 2.
- id_rs2_used  input  1  instruction reads rs2.
- id_rd_addr  input  5  ID destination register.
- id_RegWrite  input  1  ID instruction writes rd.
- id_MemRead  input  1  ID instruction is a load.
- ex_flush  input  1  kill instructions in ID and EX this cycle (branch or jump redirect).
- mem_busy  input  1  data memory not ready; whole pipeline frozen.
- wb_valid  input  1  valid instruction in WB.
- wb_RegWrite  input  1  WB instruction writes rd.
- wb_MemRead  input  1  WB instruction is a load.
- wb_rd_addr  input  5  WB destination register.
- stall_id  output  1  hold PC and IF/ID.
- ex_bubble  output  1  load NOP into ID/EX next edge.
- issue  output  1  ID instruction advances to EX this cycle.
- pending_mask  output  32  bit r set means a load targeting xr is in flight.
- outstanding  output  CNT_W  number of loads in flight.

Behaviour:
- State:
  - pending[31:0]
  - cnt[CNT_W-1:0]
  - ex_is_load: the EX-stage instruction is a tracked load.
  - ex_rd[4:0]: destination of the EX-stage instruction.
- Reset: pending=0, cnt=0, ex_is_load=0, ex_rd=0.
- While rst=1:
  - stall_id=1, issue=0, ex_bubble=0.
  - pending_mask=0, outstanding=0.
- retire = wb_valid & wb_RegWrite & wb_MemRead & (wb_rd_addr!=0).
- eff_pending = pending with bit wb_rd_addr cleared when retire is high.
  - Same-cycle bypass: the register file is write-first, so a register retiring this cycle causes no stall.
- hazard is the OR of:
  - RAW: id_rs1_used & rs1!=0 & eff_pending[rs1], or the same for rs2.
  - WAW: id_RegWrite & rd!=0 & eff_pending[rd].
  - Capacity: id_MemRead & id_RegWrite & rd!=0 & (cnt - retire) == MAX_LOADS.
- stall_id = mem_busy | (id_valid & hazard & ~ex_flush).
- issue = id_valid & ~stall_id & ~ex_flush.
- ex_bubble = ~mem_busy & ~issue (covers stall, flush and an empty ID).
- set = issue & id_RegWrite & id_MemRead & (id_rd_addr!=0).
- kill = ex_flush & ~mem_busy & ex_is_load.
- Next-state, rising edge, all updates suppressed while mem_busy=1 except retire:
  - pending[id_rd_addr] <= 1 on set.
  - pending[wb_rd_addr] <= 0 on retire.
  - pending[ex_rd] <= 0 on kill.
  - Set has priority over clear for the same index; it is legal only when retire frees that index in the same cycle.
  - cnt <= cnt + set - retire - kill.
    - Never wraps: the capacity hazard prevents overflow.
    - A retire or kill with cnt=0 is a protocol error: assertion fires, cnt saturates at 0.
  - ex_is_load <= set; ex_rd <= id_rd_addr when issue, else 0.
- Retire while mem_busy=1 is still honoured, because WB may drain during a MEM freeze.
- Kill and retire of the same register in one cycle cannot occur: EX and WB hold different instructions; asserted.
- Latency:
  - stall_id is combinational from the current state.
  - pending_mask and outstanding are registered and reflect updates one cycle after the event.
- x0 is never tracked; pending[0] is constant 0.

Test Plan:
- Load-use: lw x5 issues, next instruction add x6,x5,x1 in ID -> stall_id=1 and ex_bubble=1 each cycle until WB retires x5; in the retire cycle stall_id=0, issue=1; pending_mask returns to 0 the next cycle.
- Same-cycle bypass: pending[7]=1, retire of x7 coincides with ID reading rs2=x7 -> stall_id=0 in that cycle; pending_mask[7]=0 after the edge.
- Capacity (MAX_LOADS=2): loads to x1 and x2 in flight, third load to x3 in ID -> stall_id=1; retire of x1 in the same cycle -> issue=1, outstanding stays 2, pending_mask=0x0000000C.
- Flush: lw x9 issued (ex_is_load=1), ex_flush=1 next cycle -> pending[9] cleared, outstanding 1->0, no issue that cycle, ex_bubble=1.
- Freeze: mem_busy=1 for 3 cycles with a load in ID and a retire of x4 in cycle 2 -> stall_id=1, ex_bubble=0 throughout, no set, pending[4] cleared after cycle 2.
- Reset mid-operation: rst=1 with pending=0x00000120 and cnt=2 -> next edge pending_mask=0, outstanding=0; stall_id=1 while rst is high.
